// File: rtl/tapped_delay_chain.sv
// Purpose : WIDTH-bit shift chain of DEPTH stages with a selectable tap or an OR/AND/XOR merge over valid stages.
// Latency : tap k appears on out_data k+1 clocks after in_data is sampled (en held high); fill lags vld by one clock.
// Backpressure: none; en stalls the chain in place, outputs re-register every cycle regardless of en.
//
// Build option: define TAP_MERGE_EN to compile the merge modes (mode 1..3). Without it,
// mode is ignored and every mode value behaves as tap select (mode 0).
//
// Ports:
//   clk       : single clock, all state on rising edge
//   rst       : synchronous active-high reset; beats flush and en
//   en        : advance the chain one stage
//   flush     : invalidate every stage (data kept), beats en
//   in_valid  : qualifies in_data
//   in_data   : chain input
//   tap_sel   : tap index, values >= DEPTH clamp to DEPTH-1
//   mode      : 0 select, 1 OR-merge, 2 AND-merge, 3 XOR-merge
//   out_data  : registered tap / merge result
//   out_valid : qualifies out_data
//   fill      : registered count of valid stages
//   full      : fill == DEPTH

module tapped_delay_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(DEPTH)-1:0]   tap_sel,
    input  logic [1:0]                 mode,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       full
);

    localparam int TW     = $clog2(DEPTH);
    localparam int FW     = $clog2(DEPTH + 1);
    localparam int LAST_I = DEPTH - 1;

    // DEPTH always fits in TW+1 bits, DEPTH-1 in TW bits.
    localparam logic [TW:0]   DEPTH_T = DEPTH[TW:0];
    localparam logic [TW-1:0] LAST_T  = LAST_I[TW-1:0];
    localparam logic [FW-1:0] DEPTH_F = DEPTH[FW-1:0];

    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] vld;

    logic [TW-1:0]    tap_c;
    logic [FW-1:0]    vld_cnt;
    logic [WIDTH-1:0] nxt_dat;
    logic             nxt_vld;

    // Only reachable for non-power-of-two depths; otherwise the compare is never true.
    always_comb begin
        tap_c = tap_sel;
        if ({1'b0, tap_sel} >= DEPTH_T) begin
            tap_c = LAST_T;
        end
    end

    // Popcount of the current (pre-update) valid bits.
    always_comb begin
        vld_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            vld_cnt = vld_cnt + {{(FW-1){1'b0}}, vld[k]};
        end
    end

`ifdef TAP_MERGE_EN
    logic [WIDTH-1:0] or_acc;
    logic [WIDTH-1:0] and_acc;
    logic [WIDTH-1:0] xor_acc;
    logic             any_vld;

    // Invalid stages are skipped, so they neither set OR bits nor clear AND bits.
    always_comb begin
        or_acc  = '0;
        and_acc = '1;
        xor_acc = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[k]) begin
                or_acc  = or_acc  | stage[k];
                and_acc = and_acc & stage[k];
                xor_acc = xor_acc ^ stage[k];
            end
        end
    end

    assign any_vld = |vld;

    always_comb begin
        nxt_dat = stage[tap_c];
        nxt_vld = vld[tap_c];
        case (mode)
            2'd1: begin
                nxt_dat = or_acc;
                nxt_vld = any_vld;
            end
            2'd2: begin
                // AND accumulator starts all-ones; force zero when nothing is valid.
                nxt_dat = any_vld ? and_acc : '0;
                nxt_vld = any_vld;
            end
            2'd3: begin
                nxt_dat = xor_acc;
                nxt_vld = any_vld;
            end
            default: begin
                nxt_dat = stage[tap_c];
                nxt_vld = vld[tap_c];
            end
        endcase
    end
`else
    logic unused_mode;
    assign unused_mode = ^mode;

    always_comb begin
        nxt_dat = stage[tap_c];
        nxt_vld = vld[tap_c];
    end
`endif

    // Outputs and fill always come from the state before this edge's update, so in a
    // flush cycle they still reflect the pre-flush contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
            vld       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            fill      <= '0;
            full      <= 1'b0;
        end else begin
            out_data  <= nxt_dat;
            out_valid <= nxt_vld;
            fill      <= vld_cnt;
            full      <= (vld_cnt == DEPTH_F);
            if (flush) begin
                // Data stays put; only the qualifiers are dropped, and in_data is not taken.
                vld <= '0;
            end else if (en) begin
                stage[0] <= in_data;
                for (int k = 1; k < DEPTH; k++) begin
                    stage[k] <= stage[k-1];
                end
                vld <= {vld[DEPTH-2:0], in_valid};
            end
        end
    end

endmodule
